// File: rtl/gpu_ram_pkg.sv
// Shared types and constants for the GPU local RAM arbiter.
package gpu_ram_pkg;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_DATA_W = 32;

  localparam logic [1:0] REQ_EXT = 2'd0;
  localparam logic [1:0] REQ_LS  = 2'd1;
  localparam logic [1:0] REQ_PF  = 2'd2;

  typedef enum logic [0:0] {
    IDLE,
    PAIR2
  } arb_state_e;

  // Owner of the read issued last cycle, if any.
  typedef struct packed {
    logic       valid;
    logic [1:0] owner;
  } rv_tag_t;

endpackage

// File: rtl/gpu_ram_arb_if.sv
// Requester and RAM-side signals of the GPU local RAM arbiter.
interface gpu_ram_arb_if #(
  parameter int unsigned ADDR_W = gpu_ram_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = gpu_ram_pkg::DEF_DATA_W
);

  logic              ext_req;
  logic              ext_we;
  logic              ext_pair;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic              ext_rvalid;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;

  logic              pf_req;
  logic [ADDR_W-1:0] pf_addr;
  logic              pf_gnt;
  logic              pf_rvalid;

  logic [DATA_W-1:0] rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Requesters plus the RAM array.
  modport master (
    output ext_req, ext_we, ext_pair, ext_addr, ext_wdata,
    output ls_req, ls_we, ls_addr, ls_wdata,
    output pf_req, pf_addr,
    output ram_rdata,
    input  ext_gnt, ext_rvalid, ls_gnt, ls_rvalid, pf_gnt, pf_rvalid, rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );

  // The arbiter.
  modport slave (
    input  ext_req, ext_we, ext_pair, ext_addr, ext_wdata,
    input  ls_req, ls_we, ls_addr, ls_wdata,
    input  pf_req, pf_addr,
    input  ram_rdata,
    output ext_gnt, ext_rvalid, ls_gnt, ls_rvalid, pf_gnt, pf_rvalid, rdata,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/gpu_ram_starve_ctr.sv
// Saturating denial counter; promote is high once a requester has waited STARVE_MAX cycles.
module gpu_ram_starve_ctr #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic req,
  input  logic gnt,
  output logic promote
);

  localparam logic [7:0] MAX_CNT = 8'(STARVE_MAX);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req || gnt) begin
      cnt_d = '0;
    end else if (cnt_q != MAX_CNT) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign promote = (cnt_q == MAX_CNT);

endmodule

// File: rtl/gpu_ram_arb.sv
// Single-port GPU RAM arbiter: ext > ls > pf with starvation promotion and two-word ext phrases.
module gpu_ram_arb
  import gpu_ram_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic           sys_clk,
  input  logic           reset,
  gpu_ram_arb_if.slave   bus
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              pair_we_q, pair_we_d;
  rv_tag_t           rv_q, rv_d;

  logic              ls_promote, pf_promote;
  logic              ext_gnt, ls_gnt, pf_gnt;
  logic              we_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;
  logic [1:0]        owner_c;

  gpu_ram_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_ls_ctr (
    .sys_clk(sys_clk),
    .reset  (reset),
    .req    (bus.ls_req),
    .gnt    (ls_gnt),
    .promote(ls_promote)
  );

  gpu_ram_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pf_ctr (
    .sys_clk(sys_clk),
    .reset  (reset),
    .req    (bus.pf_req),
    .gnt    (pf_gnt),
    .promote(pf_promote)
  );

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    pair_we_d = pair_we_q;
    ext_gnt   = 1'b0;
    ls_gnt    = 1'b0;
    pf_gnt    = 1'b0;
    we_c      = 1'b0;
    addr_c    = '0;
    wdata_c   = '0;
    owner_c   = REQ_EXT;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (bus.ls_req && (ls_promote || !bus.ext_req) &&
              !(bus.pf_req && pf_promote && !ls_promote)) begin
            ls_gnt  = 1'b1;
            we_c    = bus.ls_we;
            addr_c  = bus.ls_addr;
            wdata_c = bus.ls_wdata;
            owner_c = REQ_LS;
          end else if (bus.pf_req && (pf_promote || !bus.ext_req)) begin
            pf_gnt  = 1'b1;
            addr_c  = bus.pf_addr;
            owner_c = REQ_PF;
          end else if (bus.ext_req) begin
            ext_gnt = 1'b1;
            we_c    = bus.ext_we;
            addr_c  = bus.ext_addr;
            wdata_c = bus.ext_wdata;
            // Odd base addresses fall back to a single access.
            if (bus.ext_pair && !bus.ext_addr[0]) begin
              state_d   = PAIR2;
              base_d    = bus.ext_addr;
              pair_we_d = bus.ext_we;
            end
          end
        end
        PAIR2: begin
          // Second phrase word is unconditional and cannot be pre-empted.
          ext_gnt = 1'b1;
          we_c    = pair_we_q;
          addr_c  = base_q + ADDR_W'(1);
          wdata_c = bus.ext_wdata;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rv_d       = '0;
    rv_d.valid = (ext_gnt || ls_gnt || pf_gnt) && !we_c;
    rv_d.owner = owner_c;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      pair_we_q <= 1'b0;
      rv_q      <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      pair_we_q <= pair_we_d;
      rv_q      <= rv_d;
    end
  end

  assign bus.ext_gnt    = ext_gnt;
  assign bus.ls_gnt     = ls_gnt;
  assign bus.pf_gnt     = pf_gnt;
  assign bus.ram_en     = ext_gnt || ls_gnt || pf_gnt;
  assign bus.ram_we     = we_c;
  assign bus.ram_addr   = addr_c;
  assign bus.ram_wdata  = wdata_c;
  assign bus.rdata      = bus.ram_rdata;
  assign bus.ext_rvalid = !reset && rv_q.valid && (rv_q.owner == REQ_EXT);
  assign bus.ls_rvalid  = !reset && rv_q.valid && (rv_q.owner == REQ_LS);
  assign bus.pf_rvalid  = !reset && rv_q.valid && (rv_q.owner == REQ_PF);

endmodule

// File: tb/tb_gpu_ram_arb.sv
// Bench for gpu_ram_arb: single-cycle arbitration vectors, multi-cycle sequences, read scoreboard.
module tb_gpu_ram_arb;
  import gpu_ram_pkg::*;

  logic sys_clk = 1'b0;
  logic reset;
  always #5 sys_clk = ~sys_clk;

  gpu_ram_arb_if bus ();

  gpu_ram_arb #(
    .ADDR_W    (10),
    .DATA_W    (32),
    .STARVE_MAX(8)
  ) dut (
    .sys_clk(sys_clk),
    .reset  (reset),
    .bus    (bus)
  );

  function automatic logic [31:0] init_val(input logic [9:0] a);
    return 32'hC0DE_0000 | {22'd0, a};
  endfunction

  // RAM model: one-cycle read latency, unwritten words return init_val.
  bit [31:0] mem [1024];
  bit        wr  [1024];
  always @(posedge sys_clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) begin
        mem[bus.ram_addr] <= bus.ram_wdata;
        wr[bus.ram_addr]  <= 1'b1;
      end else begin
        bus.ram_rdata <= wr[bus.ram_addr] ? mem[bus.ram_addr] : init_val(bus.ram_addr);
      end
    end
  end

  typedef struct {
    logic [1:0]  tag;
    logic [31:0] data;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic        ereq, ewe;
    logic [9:0]  eaddr;
    logic [31:0] ewd;
    logic        lreq, lwe;
    logic [9:0]  laddr;
    logic [31:0] lwd;
    logic        preq;
    logic [9:0]  paddr;
    logic [2:0]  gnt;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wd;
  } vec_t;
  vec_t vt[7];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] t, input logic [31:0] d);
    sbq.push_back('{tag: t, data: d});
  endtask

  task automatic mon();
    int         n;
    logic [1:0] t;
    sb_t        e;
    n = int'(bus.ext_rvalid) + int'(bus.ls_rvalid) + int'(bus.pf_rvalid);
    t = bus.ls_rvalid ? REQ_LS : (bus.pf_rvalid ? REQ_PF : REQ_EXT);
    if (n > 1) begin
      chk("rvalid_onehot", n, 1);
    end else if (n == 1) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rvalid_unexpected: got tag %0d, expected no rvalid", t);
      end else begin
        e = sbq.pop_front();
        chk("rv_tag", {30'd0, t}, {30'd0, e.tag});
        chk("rv_data", bus.rdata, e.data);
      end
    end
  endtask

  task automatic samp();
    @(negedge sys_clk);
    mon();
  endtask

  task automatic nxt();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clr();
    bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_pair = 1'b0;
    bus.ext_addr = '0; bus.ext_wdata = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0;
    bus.pf_req = 1'b0; bus.pf_addr = '0;
  endtask

  initial begin
    vt[0] = '{1, 0, 10'h010, 0, 0, 0, 0, 0, 0, 0, 3'b001, 0, 10'h010, 0};
    vt[1] = '{0, 0, 0, 0, 1, 1, 10'h020, 32'hDEADBEEF, 0, 0, 3'b010, 1, 10'h020, 32'hDEADBEEF};
    vt[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 10'h030, 3'b100, 0, 10'h030, 0};
    vt[3] = '{1, 0, 10'h011, 0, 1, 1, 10'h021, 32'h12345678, 1, 10'h031, 3'b001, 0, 10'h011, 0};
    vt[4] = '{0, 0, 0, 0, 1, 0, 10'h040, 0, 1, 10'h050, 3'b010, 0, 10'h040, 0};
    vt[5] = '{1, 1, 10'h3FF, 32'hCAFEF00D, 0, 0, 0, 0, 1, 10'h052, 3'b001, 1, 10'h3FF,
              32'hCAFEF00D};
    vt[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0};

    clr();
    reset = 1'b1;

    // Reset holds every output low even with a pending request.
    bus.ext_req = 1'b1; bus.ext_addr = 10'h005;
    samp();
    chk("rst_ext_gnt", bus.ext_gnt, 0);
    chk("rst_ram_en", bus.ram_en, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_rvalid", {bus.pf_rvalid, bus.ls_rvalid, bus.ext_rvalid}, 0);
    nxt(); samp(); nxt();
    reset = 1'b0; bus.ext_req = 1'b0;
    samp();
    chk("idle_ram_en", bus.ram_en, 0);
    chk("idle_gnt", {bus.pf_gnt, bus.ls_gnt, bus.ext_gnt}, 0);
    nxt();

    for (int i = 0; i < 7; i++) begin
      bus.ext_req = vt[i].ereq; bus.ext_we = vt[i].ewe;
      bus.ext_addr = vt[i].eaddr; bus.ext_wdata = vt[i].ewd;
      bus.ls_req = vt[i].lreq; bus.ls_we = vt[i].lwe;
      bus.ls_addr = vt[i].laddr; bus.ls_wdata = vt[i].lwd;
      bus.pf_req = vt[i].preq; bus.pf_addr = vt[i].paddr;
      samp();
      chk($sformatf("v%0d_gnt", i), {bus.pf_gnt, bus.ls_gnt, bus.ext_gnt}, vt[i].gnt);
      chk($sformatf("v%0d_en", i), bus.ram_en, (vt[i].gnt != 0));
      if (vt[i].gnt != 0) begin
        chk($sformatf("v%0d_addr", i), bus.ram_addr, vt[i].addr);
        chk($sformatf("v%0d_we", i), bus.ram_we, vt[i].we);
        if (vt[i].we) chk($sformatf("v%0d_wdata", i), bus.ram_wdata, vt[i].wd);
        else push(vt[i].gnt[1] ? REQ_LS : (vt[i].gnt[2] ? REQ_PF : REQ_EXT),
                  init_val(vt[i].addr));
      end
      nxt();
      clr();
      samp(); nxt();
    end

    // Three-way contention resolves over three cycles.
    bus.ext_req = 1; bus.ext_addr = 10'h010;
    bus.ls_req = 1; bus.ls_we = 1; bus.ls_addr = 10'h020; bus.ls_wdata = 32'hDEADBEEF;
    bus.pf_req = 1; bus.pf_addr = 10'h030;
    samp();
    chk("c3_ext_gnt", bus.ext_gnt, 1); chk("c3_ls_gnt0", bus.ls_gnt, 0);
    chk("c3_addr0", bus.ram_addr, 10'h010);
    push(REQ_EXT, init_val(10'h010));
    nxt(); bus.ext_req = 0;
    samp();
    chk("c3_ext_rvalid", bus.ext_rvalid, 1); chk("c3_ls_gnt", bus.ls_gnt, 1);
    chk("c3_we", bus.ram_we, 1); chk("c3_wdata", bus.ram_wdata, 32'hDEADBEEF);
    nxt(); bus.ls_req = 0;
    samp();
    chk("c3_pf_gnt", bus.pf_gnt, 1); chk("c3_addr2", bus.ram_addr, 10'h030);
    push(REQ_PF, init_val(10'h030));
    nxt(); bus.pf_req = 0;
    samp();
    chk("c3_pf_rvalid", bus.pf_rvalid, 1);
    nxt();
    bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 10'h020;
    samp(); chk("rb_ls_gnt", bus.ls_gnt, 1); push(REQ_LS, 32'hDEADBEEF);
    nxt(); bus.ls_req = 0;
    samp(); nxt();

    // Phrase write locks out a waiting ls request.
    bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 10'h040;
    bus.ext_req = 1; bus.ext_we = 1; bus.ext_pair = 1; bus.ext_addr = 10'h100;
    bus.ext_wdata = 32'h11111111;
    samp();
    chk("pw_gnt0", bus.ext_gnt, 1); chk("pw_addr0", bus.ram_addr, 10'h100);
    chk("pw_wd0", bus.ram_wdata, 32'h11111111); chk("pw_ls0", bus.ls_gnt, 0);
    nxt(); bus.ext_req = 0; bus.ext_pair = 0; bus.ext_wdata = 32'h22222222;
    samp();
    chk("pw_gnt1", bus.ext_gnt, 1); chk("pw_addr1", bus.ram_addr, 10'h101);
    chk("pw_we1", bus.ram_we, 1); chk("pw_wd1", bus.ram_wdata, 32'h22222222);
    chk("pw_ls1", bus.ls_gnt, 0);
    nxt();
    samp(); chk("pw_ls_gnt", bus.ls_gnt, 1); chk("pw_ext_idle", bus.ext_gnt, 0);
    push(REQ_LS, init_val(10'h040));
    nxt();
    // Odd base: single access only.
    bus.ls_addr = 10'h044;
    bus.ext_req = 1; bus.ext_we = 1; bus.ext_pair = 1; bus.ext_addr = 10'h101;
    bus.ext_wdata = 32'h33333333;
    samp(); chk("odd_gnt", bus.ext_gnt, 1); chk("odd_addr", bus.ram_addr, 10'h101);
    nxt(); bus.ext_req = 0; bus.ext_pair = 0;
    samp(); chk("odd_no_pair", bus.ext_gnt, 0); chk("odd_ls_gnt", bus.ls_gnt, 1);
    chk("odd_ls_addr", bus.ram_addr, 10'h044);
    push(REQ_LS, init_val(10'h044));
    nxt(); bus.ls_req = 0;
    // Phrase read back-to-back rvalids.
    bus.ext_req = 1; bus.ext_we = 0; bus.ext_pair = 1; bus.ext_addr = 10'h100;
    samp(); chk("pr_addr0", bus.ram_addr, 10'h100); push(REQ_EXT, 32'h11111111);
    nxt(); bus.ext_req = 0; bus.ext_pair = 0;
    samp(); chk("pr_gnt1", bus.ext_gnt, 1); chk("pr_addr1", bus.ram_addr, 10'h101);
    chk("pr_we1", bus.ram_we, 0); push(REQ_EXT, 32'h33333333);
    nxt();
    samp(); chk("pr_done", bus.ext_gnt, 0); nxt();

    // Starvation: ls wins on the 9th cycle, twice in a row.
    bus.ext_req = 1; bus.ext_we = 1; bus.ext_addr = 10'h200; bus.ext_wdata = '0;
    samp(); nxt();
    bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 10'h020;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 9; k++) begin
        samp();
        if (k < 8) begin
          chk($sformatf("st%0d_ls_wait%0d", r, k), bus.ls_gnt, 0);
          chk($sformatf("st%0d_ext%0d", r, k), bus.ext_gnt, 1);
        end else begin
          chk($sformatf("st%0d_ls_gnt", r), bus.ls_gnt, 1);
          chk($sformatf("st%0d_ext_held", r), bus.ext_gnt, 0);
          push(REQ_LS, (r == 0) ? 32'hDEADBEEF : init_val(10'h040));
        end
        nxt();
      end
      bus.ls_addr = 10'h040;
    end
    bus.ls_req = 0;
    samp(); chk("st_ext_resume", bus.ext_gnt, 1); nxt();

    // Both starved: ls first, then pf still beats ext.
    bus.ls_addr = 10'h050; bus.ls_req = 1; bus.pf_addr = 10'h060; bus.pf_req = 1;
    for (int k = 0; k < 8; k++) begin
      samp(); chk($sformatf("bs_ext%0d", k), bus.ext_gnt, 1); nxt();
    end
    samp(); chk("bs_ls_gnt", bus.ls_gnt, 1); chk("bs_pf_wait", bus.pf_gnt, 0);
    push(REQ_LS, init_val(10'h050));
    nxt(); bus.ls_req = 0;
    samp(); chk("bs_pf_gnt", bus.pf_gnt, 1); chk("bs_ext_held", bus.ext_gnt, 0);
    push(REQ_PF, init_val(10'h060));
    nxt(); bus.pf_req = 0;
    samp(); chk("bs_ext_resume", bus.ext_gnt, 1); nxt();
    bus.ext_req = 0;
    samp(); nxt();

    // Reset right after a pf read grant drops the rvalid.
    bus.pf_req = 1; bus.pf_addr = 10'h070;
    samp(); chk("rr_pf_gnt", bus.pf_gnt, 1);
    nxt(); bus.pf_req = 0; reset = 1;
    samp(); chk("rr_no_rvalid0", bus.pf_rvalid, 0);
    nxt(); reset = 0;
    samp(); chk("rr_no_rvalid1", bus.pf_rvalid, 0);
    nxt();

    // Reset during PAIR2 suppresses the second word.
    bus.ext_req = 1; bus.ext_we = 1; bus.ext_pair = 1; bus.ext_addr = 10'h180;
    bus.ext_wdata = 32'hAAAAAAAA;
    samp(); chk("rp_gnt0", bus.ext_gnt, 1);
    nxt(); bus.ext_req = 0; bus.ext_pair = 0; bus.ext_wdata = 32'hBBBBBBBB; reset = 1;
    samp(); chk("rp_rst_gnt", bus.ext_gnt, 0); chk("rp_rst_en", bus.ram_en, 0);
    nxt(); reset = 0;
    samp(); chk("rp_idle_gnt", bus.ext_gnt, 0); chk("rp_idle_en", bus.ram_en, 0);
    nxt();
    bus.ext_req = 1; bus.ext_we = 0; bus.ext_pair = 1; bus.ext_addr = 10'h180;
    samp(); chk("rp_rb_addr0", bus.ram_addr, 10'h180); push(REQ_EXT, 32'hAAAAAAAA);
    nxt(); bus.ext_req = 0; bus.ext_pair = 0;
    samp(); chk("rp_rb_gnt1", bus.ext_gnt, 1); chk("rp_rb_addr1", bus.ram_addr, 10'h181);
    push(REQ_EXT, init_val(10'h181));
    nxt();
    samp(); nxt();

    chk("sb_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpu_ram_arb.md
Name: gpu_ram_arb

Overview:
Arbiter and sequencer for the GPU local RAM, a 1K x 32 single-port array with one access per sys_clk. It shares the array between three requesters: the external bus port (host/blitter access to GPU space), the GPU load/store unit, and the GPU instruction prefetcher. It drives the RAM address, enable and write strobes, and returns tagged read-valid strobes. It supports two-word (phrase) external transfers and guarantees forward progress through starvation counters.

Parameters:
ADDR_W, 10, RAM word-address width (byte address bits [11:2])
DATA_W, 32, RAM word width
STARVE_MAX, 8, consecutive denied cycles before a requester is promoted (range 1..255)

Ports:
sys_clk  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high
ext_req  in  1  external access request, held until ext_gnt
ext_we  in  1  1=write, 0=read
ext_pair  in  1  two-word transfer; honoured only when ext_addr[0]=0
ext_addr  in  ADDR_W  word address
ext_wdata  in  DATA_W  write word; second word presented in the cycle after first ext_gnt
ext_gnt  out  1  access issued this cycle
ext_rvalid  out  1  rdata holds ext read data
ls_req/ls_we/ls_addr/ls_wdata  in  1/1/ADDR_W/DATA_W  load/store request, held until ls_gnt
ls_gnt, ls_rvalid  out  1 each
pf_req/pf_addr  in  1/ADDR_W  prefetch read request, held until pf_gnt
pf_gnt, pf_rvalid  out  1 each
rdata  out  DATA_W  shared read return, equals ram_rdata
ram_en  out  1  RAM access this cycle
ram_we  out  1  RAM write this cycle
ram_addr  out  ADDR_W  RAM word address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid one cycle after a read access

Behaviour:
- Reset: state=IDLE, starvation counters=0, rvalid pipeline cleared. While reset is high, all gnt, rvalid, ram_en and ram_we outputs are 0, ram_addr and ram_wdata are 0.
- Grants are combinational from the current req inputs and registered state. At most one gnt per cycle. ram_en equals the OR of the gnts. ram_we, ram_addr and ram_wdata come from the granted requester.
- Base priority: ext > ls > pf.
- Starvation: ls_cnt and pf_cnt each increment (saturating at STARVE_MAX) when req=1 and gnt=0, and clear on gnt or req=0. A counter at STARVE_MAX promotes its requester above ext. If both counters are saturated, ls wins.
- FSM:
  - IDLE to PAIR2 when ext is granted with ext_pair=1 and ext_addr[0]=0.
  - PAIR2 unconditionally grants ext (ext_gnt=1, ignoring ext_req) at the latched base address +1 with the latched ext_we. For writes it uses ext_wdata; for reads it issues the second read. PAIR2 then returns to IDLE.
  - PAIR2 is not pre-emptible, including by starved requesters. Their counters keep counting.
- ext_pair with odd ext_addr: treated as a single access, no PAIR2.
- Address arithmetic: pair increment is ADDR_W-bit. The base is even, so no wrap past 1023 is possible.
- Read latency: a read granted in cycle N asserts the matching rvalid in cycle N+1, with rdata=ram_rdata. A write produces no rvalid. A one-entry tag register (2 bits plus valid) records the read owner.
- Back-to-back reads by any requester are allowed. rvalid can be 1 in consecutive cycles.
- Requester contract: req, addr, we and wdata are stable while req=1 and gnt=0. After gnt the requester may drop req or present its next request in the same cycle.
- Reset mid-PAIR2 or with a read in flight: the FSM returns to IDLE and no rvalid is produced for the aborted access.

Decomposition:
- Package gpu_ram_pkg: ADDR_W/DATA_W defaults, requester index constants (REQ_EXT=0, REQ_LS=1, REQ_PF=2), the arbiter state enum (IDLE, PAIR2) and the rvalid tag type.
- Sub-module gpu_ram_starve_ctr: saturating counter with req/gnt inputs and a promote output. Instantiated for ls and pf.

Test Plan:
- Reset then idle: all req=0 -> ram_en=0, all gnt/rvalid=0. Hold reset with ext_req=1 -> ext_gnt stays 0.
- Simultaneous ext_req (read 0x010), ls_req (write 0x020, data 0xDEADBEEF) and pf_req (0x030):
  - cycle0: ext_gnt, ram_addr=0x010.
  - cycle1: ext_rvalid, ls_gnt, ram_we=1, ram_wdata=0xDEADBEEF.
  - cycle2: pf_gnt. cycle3: pf_rvalid.
- Phrase write: ext_pair=1, ext_addr=0x100, data 0x11111111 then 0x22222222 -> ext_gnt two consecutive cycles at ram_addr 0x100 and 0x101, while ls_req held high gets no grant in between. Repeat with ext_addr=0x101 -> single write only.
- Starvation: ext_req held high continuously with STARVE_MAX=8, ls_req=1 -> ls_gnt in the 9th cycle after ls_req rises, ls_cnt clears, ext resumes the next cycle.
- Both starved: ext saturating and ls/pf held for 8 cycles -> ls granted first. pf remains promoted and is granted the next cycle.
- Reset asserted the cycle after a pf read grant -> pf_rvalid is never asserted. Reset asserted during PAIR2 -> no second access, state IDLE afterwards.
